// File: rtl/blink_div_multi.sv
// Purpose     : multi-channel level-programmable blink-rate divider driving the player/LED blink outputs.
// Latency     : tick/phase update one clk after the boundary edge; sclk is combinational from registered state.
// Backpressure: none; free-running outputs, no handshake.
//
// Ports
//   clk    in   1             system clock, all logic on posedge
//   rst_n  in   1             synchronous active-low reset
//   en     in   NUM_CH        per-channel run enable
//   level  in   NUM_CH*LVL_W  per-channel level, ch i at [i*LVL_W +: LVL_W]
//   mode   in   NUM_CH*2      per-channel output mode (00 square, 01 pulse, 10 solid, 11 off)
//   sync   in   1             one-cycle strobe, realigns every channel to phase 0
//   sclk   out  NUM_CH        per-channel blink output (mode-selected)
//   tick   out  NUM_CH        one-cycle strobe at each half-period boundary
//
// Each channel counts (MAX_LVL - eff_lvl) * STEP cycles per half-period, where
// eff_lvl is the shadowed level clamped to MAX_LVL-1, so the half-period is never zero.
module blink_div_multi #(
   parameter int NUM_CH  = 2,
   parameter int LVL_W   = 4,
   parameter int MAX_LVL = 11,
   parameter int STEP    = 1_500_000,
   parameter int CNT_W   = 25
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH*LVL_W-1:0] level,
   input  logic [NUM_CH*2-1:0]     mode,
   input  logic                    sync,
   output logic [NUM_CH-1:0]       sclk,
   output logic [NUM_CH-1:0]       tick
);

   // Output mode encodings.
   localparam logic [1:0] LP_MODE_SQUARE = 2'b00;
   localparam logic [1:0] LP_MODE_PULSE  = 2'b01;
   localparam logic [1:0] LP_MODE_SOLID  = 2'b10;
   localparam logic [1:0] LP_MODE_OFF    = 2'b11;

   // Highest level that still leaves a non-zero half-period.
   localparam logic [LVL_W-1:0] LP_LVL_CEIL = LVL_W'(MAX_LVL - 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity.
   // ------------------------------------------------------------------
   if ((longint'(MAX_LVL) * longint'(STEP) - 1) >= (longint'(1) << CNT_W)) begin : g_cnt_w_chk
      $error("blink_div_multi: CNT_W=%0d cannot hold MAX_LVL*STEP-1", CNT_W);
   end
   if (MAX_LVL < 2 || STEP < 1) begin : g_lvl_chk
      $error("blink_div_multi: MAX_LVL must be >= 2 and STEP >= 1");
   end
   if ((MAX_LVL - 1) >= (1 << LVL_W)) begin : g_ceil_chk
      $error("blink_div_multi: MAX_LVL-1 does not fit in LVL_W bits");
   end

   // ------------------------------------------------------------------
   // Per-channel registered state.
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt    [NUM_CH];
   logic [LVL_W-1:0] r_lvl_sh [NUM_CH];
   logic [NUM_CH-1:0] r_phase;
   logic [NUM_CH-1:0] r_tick;

   // ------------------------------------------------------------------
   // Half-period terminal count derived from the shadow level only, so a
   // level change on the input never moves the boundary of the half-period
   // currently in flight.
   // ------------------------------------------------------------------
   logic [LVL_W-1:0] w_eff_lvl  [NUM_CH];
   logic [CNT_W-1:0] w_half_m1  [NUM_CH];
   logic [NUM_CH-1:0] w_boundary;

   always_comb begin
      w_boundary = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_eff_lvl[i] = (r_lvl_sh[i] > LP_LVL_CEIL) ? LP_LVL_CEIL : r_lvl_sh[i];
         w_half_m1[i] = CNT_W'((MAX_LVL - int'(w_eff_lvl[i])) * STEP - 1);
         w_boundary[i] = (r_cnt[i] == w_half_m1[i]);
      end
   end

   // ------------------------------------------------------------------
   // Counter / phase / tick / shadow-level update.
   // Priority: reset > sync > per-channel enable > boundary > count.
   // Idle and sync share the same target state: counter parked at zero and
   // the shadow level following the input, so enabling restarts a clean
   // half-period at whatever level is presented.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i]    <= '0;
            r_lvl_sh[i] <= '0;
         end
         r_phase <= '0;
         r_tick  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync || !en[i]) begin
               r_cnt[i]    <= '0;
               r_phase[i]  <= 1'b0;
               r_tick[i]   <= 1'b0;
               r_lvl_sh[i] <= level[i*LVL_W +: LVL_W];
            end else if (w_boundary[i]) begin
               r_cnt[i]    <= '0;
               r_phase[i]  <= ~r_phase[i];
               r_tick[i]   <= 1'b1;
               r_lvl_sh[i] <= level[i*LVL_W +: LVL_W];
            end else begin
               r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
               r_tick[i]   <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output mode mux; purely combinational so a mode switch never touches
   // the running counter or phase.
   // ------------------------------------------------------------------
   always_comb begin
      sclk = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (mode[i*2 +: 2])
            LP_MODE_SQUARE: sclk[i] = r_phase[i];
            LP_MODE_PULSE:  sclk[i] = r_tick[i];
            LP_MODE_SOLID:  sclk[i] = 1'b1;
            LP_MODE_OFF:    sclk[i] = 1'b0;
            default:        sclk[i] = 1'b0;
         endcase
      end
   end

   assign tick = r_tick;

endmodule

// File: tb/tb_blink_div_multi.sv
// Purpose     : directed self-checking bench for blink_div_multi (STEP=4, MAX_LVL=11, NUM_CH=2).
// Latency     : checks sampled 1 time unit after each posedge.
// Backpressure: n/a.
module tb_blink_div_multi;

   localparam int NUM_CH  = 2;
   localparam int LVL_W   = 4;
   localparam int MAX_LVL = 11;
   localparam int STEP    = 4;
   localparam int CNT_W   = 8;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       en;
   logic [NUM_CH*LVL_W-1:0] level;
   logic [NUM_CH*2-1:0]     mode;
   logic                    sync;
   logic [NUM_CH-1:0]       sclk;
   logic [NUM_CH-1:0]       tick;

   int errors = 0;
   int checks = 0;

   blink_div_multi #(
      .NUM_CH (NUM_CH),
      .LVL_W  (LVL_W),
      .MAX_LVL(MAX_LVL),
      .STEP   (STEP),
      .CNT_W  (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .level(level),
      .mode (mode),
      .sync (sync),
      .sclk (sclk),
      .tick (tick)
   );

   always #5 clk = ~clk;

   // Advance one posedge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One idle edge loads the shadow level, then ch0 is enabled; the next
   // step() is enabled edge 1.
   task automatic arm_ch0(input logic [LVL_W-1:0] lvl);
      en[0] = 1'b0;
      level[LVL_W-1:0] = lvl;
      step();
      en[0] = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = '0; level = '0; mode = '0; sync = 1'b0;
      step();
      step();
      checks++;
      if (sclk !== 2'b00) begin errors++; $display("FAIL reset_sclk: got %b want 00", sclk); end
      checks++;
      if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b want 00", tick); end
      // Enable held during reset must not start anything.
      en = 2'b11;
      step();
      step();
      checks++;
      if (tick !== 2'b00 || sclk !== 2'b00) begin
         errors++; $display("FAIL reset_en_held: got tick=%b sclk=%b want 00/00", tick, sclk);
      end
      en = '0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_square_basic();
      logic exp_t, exp_s;
      mode = '0;
      arm_ch0(4'd10);
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_t = (k % 4 == 0);
         exp_s = ((k / 4) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t) begin errors++; $display("FAIL basic_tick0 edge %0d: got %b want %b", k, tick[0], exp_t); end
         checks++;
         if (sclk[0] !== exp_s) begin errors++; $display("FAIL basic_sclk0 edge %0d: got %b want %b", k, sclk[0], exp_s); end
         checks++;
         if (tick[1] !== 1'b0 || sclk[1] !== 1'b0) begin
            errors++; $display("FAIL basic_ch1_idle edge %0d: got tick=%b sclk=%b want 0/0", k, tick[1], sclk[1]);
         end
      end
   endtask

   task automatic test_clamp();
      logic exp_t, exp_s;
      arm_ch0(4'd15);
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_t = (k % 4 == 0);
         exp_s = ((k / 4) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t || sclk[0] !== exp_s) begin
            errors++; $display("FAIL clamp15 edge %0d: got tick=%b sclk=%b want %b/%b", k, tick[0], sclk[0], exp_t, exp_s);
         end
      end
      arm_ch0(4'd0);
      for (int k = 1; k <= 90; k++) begin
         step();
         exp_t = (k % 44 == 0);
         exp_s = ((k / 44) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t || sclk[0] !== exp_s) begin
            errors++; $display("FAIL level0 edge %0d: got tick=%b sclk=%b want %b/%b", k, tick[0], sclk[0], exp_t, exp_s);
         end
      end
   endtask

   task automatic test_level_reload();
      logic exp_t, exp_s;
      arm_ch0(4'd0);
      for (int k = 1; k <= 56; k++) begin
         if (k == 6) level[LVL_W-1:0] = 4'd10;
         step();
         exp_t = (k == 44) || (k > 44 && (k - 44) % 4 == 0);
         exp_s = (k >= 44) && ((1 + (k - 44) / 4) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t || sclk[0] !== exp_s) begin
            errors++; $display("FAIL reload edge %0d: got tick=%b sclk=%b want %b/%b", k, tick[0], sclk[0], exp_t, exp_s);
         end
      end
   endtask

   task automatic test_sync();
      logic [1:0] exp_t, exp_s;
      en = 2'b00;
      level = {4'd9, 4'd10};
      mode = '0;
      step();
      en = 2'b11;
      for (int k = 1; k <= 6; k++) step();
      checks++;
      if (sclk !== 2'b01) begin errors++; $display("FAIL sync_pre: got sclk=%b want 01", sclk); end
      sync = 1'b1;
      step();
      sync = 1'b0;
      checks++;
      if (sclk !== 2'b00 || tick !== 2'b00) begin
         errors++; $display("FAIL sync_edge: got sclk=%b tick=%b want 00/00", sclk, tick);
      end
      for (int j = 1; j <= 16; j++) begin
         step();
         exp_t = {(j % 8 == 0), (j % 4 == 0)};
         exp_s = {((j / 8) % 2 == 1), ((j / 4) % 2 == 1)};
         checks++;
         if (tick !== exp_t || sclk !== exp_s) begin
            errors++; $display("FAIL sync_after edge %0d: got tick=%b sclk=%b want %b/%b", j, tick, sclk, exp_t, exp_s);
         end
      end
   endtask

   task automatic test_modes();
      logic exp_t, exp_s;
      en = 2'b00;
      mode = '0;
      arm_ch0(4'd10);
      for (int k = 1; k <= 16; k++) begin
         if (k <= 4)       mode[1:0] = 2'b01;
         else if (k <= 8)  mode[1:0] = 2'b10;
         else if (k <= 12) mode[1:0] = 2'b11;
         else              mode[1:0] = 2'b00;
         step();
         exp_t = (k % 4 == 0);
         if (k <= 4)       exp_s = exp_t;
         else if (k <= 8)  exp_s = 1'b1;
         else if (k <= 12) exp_s = 1'b0;
         else              exp_s = ((k / 4) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t) begin errors++; $display("FAIL mode_tick edge %0d: got %b want %b", k, tick[0], exp_t); end
         checks++;
         if (sclk[0] !== exp_s) begin errors++; $display("FAIL mode_sclk edge %0d mode %b: got %b want %b", k, mode[1:0], sclk[0], exp_s); end
      end
   endtask

   task automatic test_reset_and_en_drop();
      logic exp_t, exp_s;
      mode = '0;
      en = 2'b00;
      arm_ch0(4'd10);
      for (int k = 1; k <= 6; k++) step();
      checks++;
      if (sclk[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre: got sclk0=%b want 1", sclk[0]); end
      rst_n = 1'b0;
      step();
      checks++;
      if (sclk[0] !== 1'b0 || tick[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_edge: got sclk0=%b tick0=%b want 0/0", sclk[0], tick[0]);
      end
      rst_n = 1'b1;
      // Shadow level was cleared by reset and en stayed high, so the first
      // half-period is the level-0 one (44), then level 10 (4) takes over.
      for (int j = 1; j <= 54; j++) begin
         step();
         exp_t = (j == 44) || (j > 44 && (j - 44) % 4 == 0);
         exp_s = (j >= 44) && ((1 + (j - 44) / 4) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t || sclk[0] !== exp_s) begin
            errors++; $display("FAIL postrst edge %0d: got tick=%b sclk=%b want %b/%b", j, tick[0], sclk[0], exp_t, exp_s);
         end
      end
      en[0] = 1'b0;
      step();
      checks++;
      if (sclk[0] !== 1'b0 || tick[0] !== 1'b0) begin
         errors++; $display("FAIL endrop_edge: got sclk0=%b tick0=%b want 0/0", sclk[0], tick[0]);
      end
      en[0] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         step();
         exp_t = (j % 4 == 0);
         exp_s = ((j / 4) % 2 == 1);
         checks++;
         if (tick[0] !== exp_t || sclk[0] !== exp_s) begin
            errors++; $display("FAIL enrestart edge %0d: got tick=%b sclk=%b want %b/%b", j, tick[0], sclk[0], exp_t, exp_s);
         end
      end
   endtask

   initial begin
      test_reset();
      test_square_basic();
      test_clamp();
      test_level_reload();
      test_sync();
      test_modes();
      test_reset_and_en_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
